// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory responder: word-addressed RAM behind a fixed multi-cycle
// access latency, with pipeline stall and illegal-address flagging.
module dmem_ctrl #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AddrErr
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        wdata;
    logic               op_write;
    logic               req;
    logic               legal;
    logic               accept;
    logic               access;
    logic [31:0]        mem [DEPTH];

    assign req   = MemRead | MemWrite;
    assign legal = (MemRead ^ MemWrite) && (Addr[1:0] == 2'b00)
                   && (Addr[31:2] < 30'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Stall is gated by rst_n so a held request cannot freeze the pipe during reset.
    always_comb begin
        next_state = state;
        Stall      = 1'b0;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (legal) begin
                    accept     = 1'b1;
                    Stall      = rst_n;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (cnt == '0) begin
                    access     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idx      <= '0;
            wdata    <= '0;
            op_write <= 1'b0;
            ReadData <= '0;
            AddrErr  <= 1'b0;
        end else begin
            AddrErr <= (state == IDLE) && req && !legal;
            if (accept) begin
                op_write <= MemWrite;
                idx      <= Addr[IDX_W+1:2];
                wdata    <= WriteData;
                cnt      <= CNT_W'(LATENCY - 1);
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (access && !op_write) begin
                ReadData <= mem[idx];
            end
        end
    end

    // RAM array is deliberately not reset; access is already forced low while in reset.
    always_ff @(posedge clk) begin
        if (access && op_write) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory responder for the MEM stage of the MIPS core. Consumes the MemRead/MemWrite requests issued by the main control decoder.
- Models a word-addressed data RAM with a configurable multi-cycle access latency.
- Asserts Stall to freeze the pipeline until the access completes.
- Flags misaligned or out-of-range accesses without touching memory.

Parameters:
- DEPTH, 256, number of 32-bit words in the RAM (power of two).
- LATENCY, 2, wait cycles before the access is performed (legal range 1..15).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- MemRead  input  1  load request from EX/MEM register
- MemWrite  input  1  store request from EX/MEM register
- Addr  input  32  byte address (ALU result)
- WriteData  input  32  store data
- ReadData  output  32  load result, held until the next load completes
- Stall  output  1  pipeline freeze, combinational from state and request
- AddrErr  output  1  one-cycle pulse on an illegal request

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wait counter=0, ReadData=0, AddrErr=0, Stall=0. RAM contents are not cleared. Reset mid-access abandons the access; a pending store is not written.
- Legal request: exactly one of MemRead/MemWrite=1, Addr[1:0]==0, and Addr[31:2] < DEPTH.
- Illegal request: any other combination with MemRead|MemWrite=1, including both bits high.
- Illegal request in IDLE: AddrErr=1 on the next cycle for one cycle. No stall, no RAM access, ReadData unchanged, state stays IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE, legal request at cycle 0:
  - Stall=1 combinationally.
  - On the edge: latch op, word index (Addr[31:2]) and WriteData; counter=LATENCY-1; go to BUSY.
- BUSY:
  - Stall=1.
  - If counter!=0: decrement.
  - If counter==0: perform the access (store: RAM[idx]<=latched data; load: ReadData<=RAM[idx]) and go to DONE.
  - Request inputs are ignored while BUSY; deasserting them does not cancel the access.
- DONE:
  - Stall=0 for exactly one cycle, so the pipeline advances on this edge.
  - ReadData is valid.
  - Inputs are ignored (they still show the completed instruction); next state is IDLE.
- Timing: Stall is high for cycles 0..LATENCY (LATENCY+1 cycles) and low in the DONE cycle LATENCY+1. A new request is accepted at the earliest in cycle LATENCY+2.
- No request in IDLE: Stall=0, nothing changes.
- A store never modifies ReadData.
- A load from a just-written address returns the new data (the store completes before the load is latched).
- The counter is 4 bits wide and never wraps.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with MemRead=1, Addr=0x10 -> Stall=0, ReadData=0, AddrErr=0; after release, the access starts on the first edge.
- Store then load, LATENCY=2:
  - Store: MemWrite=1, Addr=0x20, WriteData=0xDEADBEEF -> Stall high for 3 cycles, low 1 cycle.
  - Load: MemRead=1, Addr=0x20 -> ReadData=0xDEADBEEF in the DONE cycle, still 0xDEADBEEF 5 cycles later.
- Misaligned access: MemRead=1, Addr=0x22 -> AddrErr pulses 1 cycle, Stall stays 0, ReadData unchanged.
- Out-of-range access: MemWrite=1, Addr=0x400 (DEPTH=256) -> AddrErr=1 for 1 cycle; a subsequent load of Addr=0x0 returns its previous value.
- Both requests: MemRead=1 and MemWrite=1, Addr=0x8 -> AddrErr pulse, no stall, RAM[2] unchanged.
- Abort and request-drop:
  - Drop MemWrite after cycle 0 of a store to 0x30, data 0x12345678 -> write still completes, Stall timing unchanged.
  - Repeat with rst_n pulsed low in BUSY -> RAM[12] keeps its old value, state=IDLE, Stall=0.
